matrix_stream_loader: RTL and testbench

- Upstream feeder for the 4x4 systolic array multiplier.
- Accepts a byte stream over a valid/ready handshake and assembles matrix A, then matrix B, in row-major order.
- Presents both matrices in parallel and pulses o_validInput for one cycle.
- Then stalls the stream until the array reports i_validResult, so a new operand pair is never launched over a computation in flight.

---
 rtl/systolic_pkg.sv | 15 +
 rtl/matrix_capture.sv | 28 ++
 rtl/matrix_stream_loader.sv | 80 ++++++++
 tb/tb_matrix_stream_loader.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and constants for the 4x4 systolic array and its operand loader.
package systolic_pkg;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = $clog2(N * N);

    typedef logic [N-1:0][N-1:0][W-1:0] mat_t;
    typedef logic [IW-1:0]              idx_t;

    typedef enum logic [1:0] {LOAD_A, LOAD_B, FIRE, WAIT} state_t;

    localparam idx_t LAST_IDX = idx_t'(N * N - 1);

endpackage

// File: rtl/matrix_capture.sv
// matrix_capture: N*N element register file written one element at a time by flat row-major index.
module matrix_capture
    import systolic_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_arst_n,
    input  logic         i_we,
    input  idx_t         i_idx,
    input  logic [W-1:0] i_data,
    output mat_t         o_mat
);

    // Flat element k sits at packed offset k*W, which is exactly mat[k/N][k%N].
    logic [N*N-1:0][W-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (i_we) mem_d[i_idx] = i_data;
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) mem_q <= '0;
        else           mem_q <= mem_d;
    end

    assign o_mat = mem_q;

endmodule

// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: assembles A then B from a byte stream, launches both to the array,
// then holds off the stream until the array returns its result.
module matrix_stream_loader
    import systolic_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_arst_n,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output mat_t         o_a,
    output mat_t         o_b,
    output logic         o_validInput,
    input  logic         i_validResult,
    output logic         o_busy
);

    state_t state_q, state_d;
    idx_t   idx_q, idx_d;
    logic   ready_q, ready_d, fire_q, fire_d, busy_q, busy_d;
    logic   xfer, last;

    assign xfer = i_valid && ready_q;
    assign last = xfer && (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        idx_d   = xfer ? idx_q + 1'b1 : idx_q;
        case (state_q)
            LOAD_A:  state_d = last ? LOAD_B : LOAD_A;
            LOAD_B:  state_d = last ? FIRE : LOAD_B;
            FIRE:    state_d = WAIT;
            WAIT:    state_d = i_validResult ? LOAD_A : WAIT;
            default: state_d = LOAD_A;
        endcase
        // Handshake outputs are registered from the next state so nothing depends on i_valid combinationally.
        ready_d = (state_d == LOAD_A) || (state_d == LOAD_B);
        fire_d  = (state_d == FIRE);
        busy_d  = (state_d == WAIT);
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= LOAD_A;
            idx_q   <= '0;
            ready_q <= 1'b1;
            fire_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            fire_q  <= fire_d;
            busy_q  <= busy_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_validInput = fire_q;
    assign o_busy       = busy_q;

    matrix_capture u_cap_a (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_we     (xfer && (state_q == LOAD_A)),
        .i_idx    (idx_q),
        .i_data   (i_data),
        .o_mat    (o_a)
    );

    matrix_capture u_cap_b (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_we     (xfer && (state_q == LOAD_B)),
        .i_idx    (idx_q),
        .i_data   (i_data),
        .o_mat    (o_b)
    );

endmodule

// File: tb/tb_matrix_stream_loader.sv
// tb_matrix_stream_loader: directed streams; expected launches go into a scoreboard checked by a monitor.
module tb_matrix_stream_loader;
    import systolic_pkg::*;

    logic         i_clk = 1'b0;
    logic         i_arst_n;
    logic [W-1:0] i_data;
    logic         i_valid;
    logic         o_ready;
    mat_t         o_a, o_b;
    logic         o_validInput;
    logic         i_validResult;
    logic         o_busy;

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        int           t;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0, n_total = 0;
    int   cyc = 0, last_t = 0, n_pushed = 0, n_seen = 0;

    matrix_stream_loader dut (
        .i_clk         (i_clk),
        .i_arst_n      (i_arst_n),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .o_a           (o_a),
        .o_b           (o_b),
        .o_validInput  (o_validInput),
        .i_validResult (i_validResult),
        .o_busy        (o_busy)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [127:0] mk(input logic [7:0] base);
        logic [127:0] m;
        for (int k = 0; k < 16; k++) m[k*8 +: 8] = 8'(base + k);
        return m;
    endfunction

    // Monitor: every launch pulse must match the oldest expected operand pair and its cycle.
    always @(negedge i_clk) begin
        if (i_arst_n && o_validInput) begin
            n_seen++;
            if (exp_q.size() == 0) begin
                check("spurious_launch", 128'(1), 128'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("launch_a", 128'(o_a), e.a);
                check("launch_b", 128'(o_b), e.b);
                check("launch_cycle", 128'(cyc), 128'(e.t));
            end
        end
    end

    task automatic send(input logic [7:0] d);
        @(negedge i_clk);
        i_valid = 1'b1;
        i_data  = d;
        @(posedge i_clk);
        #1;
        last_t  = cyc;
        i_valid = 1'b0;
        i_data  = 8'h00;
    endtask

    task automatic load(input logic [7:0] base, input int gap);
        for (int k = 0; k < 32; k++) begin
            send(8'(base + k));
            if (k < 31) repeat (gap) @(posedge i_clk);
        end
        exp_q.push_back('{mk(base), mk(8'(base + 16)), last_t});
        n_pushed++;
    endtask

    task automatic ret(input int k);
        repeat (k) @(negedge i_clk);
        check("busy_before_result", 128'(o_busy), 128'(1));
        i_validResult = 1'b1;
        @(posedge i_clk);
        #1;
        i_validResult = 1'b0;
        @(negedge i_clk);
        check("ready_after_result", 128'(o_ready), 128'(1));
        check("busy_after_result", 128'(o_busy), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_arst_n = 1'b0;
        i_valid = 1'b0;
        i_data = 8'h00;
        i_validResult = 1'b0;
        repeat (2) @(negedge i_clk);
        check("rst_ready", 128'(o_ready), 128'(1));
        check("rst_fire", 128'(o_validInput), 128'(0));
        check("rst_busy", 128'(o_busy), 128'(0));
        check("rst_a", 128'(o_a), 128'(0));
        check("rst_b", 128'(o_b), 128'(0));
        i_arst_n = 1'b1;

        load(8'd1, 0);
        check("a00", 128'(o_a[0][0]), 128'(1));
        check("a33", 128'(o_a[3][3]), 128'(16));
        check("b01", 128'(o_b[0][1]), 128'(18));
        check("b33", 128'(o_b[3][3]), 128'(32));
        @(negedge i_clk);
        i_valid = 1'b1;
        i_data = 8'hFF;
        repeat (20) @(negedge i_clk);
        check("wait_ready", 128'(o_ready), 128'(0));
        check("wait_busy", 128'(o_busy), 128'(1));
        check("wait_a_hold", 128'(o_a), mk(8'd1));
        check("wait_b_hold", 128'(o_b), mk(8'd17));
        i_valid = 1'b0;
        ret(1);

        load(8'd1, 1);
        ret(7);

        i_validResult = 1'b1;
        load(8'h20, 0);
        @(posedge i_clk);
        #1;
        i_validResult = 1'b0;
        repeat (3) @(negedge i_clk);
        check("ignored_result_busy", 128'(o_busy), 128'(1));
        check("ignored_result_ready", 128'(o_ready), 128'(0));
        ret(1);

        for (int k = 0; k < 26; k++) send(8'(8'h50 + k));
        @(negedge i_clk);
        i_arst_n = 1'b0;
        #1;
        check("midrst_a", 128'(o_a), 128'(0));
        check("midrst_b", 128'(o_b), 128'(0));
        check("midrst_ready", 128'(o_ready), 128'(1));
        @(negedge i_clk);
        i_arst_n = 1'b1;
        load(8'h60, 0);
        ret(7);

        load(8'h00, 0);
        ret(7);
        load(8'h80, 0);
        check("second_a00", 128'(o_a[0][0]), 128'(8'h80));
        check("second_b33", 128'(o_b[3][3]), 128'(8'h9F));
        ret(7);

        repeat (3) @(negedge i_clk);
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        check("launch_count", 128'(n_seen), 128'(n_pushed));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
